// File: rtl/vga_pkg.sv
// Shared constants and FSM encoding for the VGA draw scheduler.
// Screen limits for both resolution modes and the fixed colour width.
package vga_pkg;
  localparam int XMAX_LO  = 160;
  localparam int YMAX_LO  = 120;
  localparam int XMAX_HI  = 320;
  localparam int YMAX_HI  = 240;
  localparam int COLOUR_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after i_ptr wins.
// The pointer register lives in the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);
  int w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = (int'(i_ptr) + k) % NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!o_any && (j == w_cand) && i_req[j]) begin
          o_any      = 1'b1;
          o_idx      = IW'(j);
          o_grant[j] = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/vga_draw_scheduler.sv
// Shares one VGA pixel-write port between NUM_REQ rectangle-fill requesters,
// round-robin granted and rastered one pixel per cycle with screen clipping.
module vga_draw_scheduler
  import vga_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XW      = 9,
  parameter int YW      = 8
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic                           vga_resolution_mode,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*XW-1:0]          req_x0,
  input  logic [NUM_REQ*YW-1:0]          req_y0,
  input  logic [NUM_REQ*XW-1:0]          req_w,
  input  logic [NUM_REQ*YW-1:0]          req_h,
  input  logic [NUM_REQ*COLOUR_W-1:0]    req_colour,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [NUM_REQ-1:0]             req_done,
  output logic                           busy,
  output logic [XW-1:0]                  x,
  output logic [YW-1:0]                  y,
  output logic [COLOUR_W-1:0]            colour,
  output logic                           writeEn
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                r_state, w_state;
  logic [IW-1:0]         r_ptr, w_ptr, r_idx, w_idx_n;
  logic [XW-1:0]         r_x0, w_x0, r_w, w_w, r_cx, w_cx, r_x, w_x;
  logic [YW-1:0]         r_y0, w_y0, r_h, w_h, r_cy, w_cy, r_y, w_y;
  logic [COLOUR_W-1:0]   r_col, w_col;
  logic                  r_mode, w_mode, r_empty, w_empty, r_we, w_we, r_busy, w_busy;
  logic [NUM_REQ-1:0]    r_ack, w_ack, r_done, w_done;

  logic [NUM_REQ-1:0]    w_grant;
  logic [IW-1:0]         w_idx;
  logic                  w_any;
  logic [XW-1:0]         w_sel_x0, w_sel_w;
  logic [YW-1:0]         w_sel_y0, w_sel_h;
  logic [COLOUR_W-1:0]   w_sel_col;
  logic                  w_last;

  // Clip test done one bit wider than the coordinates so off-screen pixels never wrap on-screen.
  function automatic logic in_bounds(input logic [XW-1:0] bx, input logic [XW-1:0] ox,
                                     input logic [YW-1:0] by, input logic [YW-1:0] oy,
                                     input logic hi);
    logic [XW:0] px;
    logic [YW:0] py;
    px = {1'b0, bx} + {1'b0, ox};
    py = {1'b0, by} + {1'b0, oy};
    if (hi) return (px < (XW+1)'(XMAX_HI)) && (py < (YW+1)'(YMAX_HI));
    else    return (px < (XW+1)'(XMAX_LO)) && (py < (YW+1)'(YMAX_LO));
  endfunction

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_sel_x0  = '0;
    w_sel_y0  = '0;
    w_sel_w   = '0;
    w_sel_h   = '0;
    w_sel_col = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_idx == IW'(i)) begin
        w_sel_x0  = req_x0[i*XW +: XW];
        w_sel_y0  = req_y0[i*YW +: YW];
        w_sel_w   = req_w[i*XW +: XW];
        w_sel_h   = req_h[i*YW +: YW];
        w_sel_col = req_colour[i*COLOUR_W +: COLOUR_W];
      end
    end
  end

  assign w_last = r_empty || ((r_cx == r_w - XW'(1)) && (r_cy == r_h - YW'(1)));

  always_comb begin
    w_state = r_state;  w_ptr  = r_ptr;   w_idx_n = r_idx;
    w_x0    = r_x0;     w_y0   = r_y0;    w_w     = r_w;    w_h  = r_h;
    w_col   = r_col;    w_mode = r_mode;  w_empty = r_empty;
    w_cx    = r_cx;     w_cy   = r_cy;    w_x     = r_x;    w_y  = r_y;
    w_busy  = r_busy;   w_we   = 1'b0;    w_ack   = '0;     w_done = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          // First pixel is presented in the same cycle as the ack.
          w_state = S_DRAW;
          w_idx_n = w_idx;
          w_x0    = w_sel_x0;
          w_y0    = w_sel_y0;
          w_w     = w_sel_w;
          w_h     = w_sel_h;
          w_col   = w_sel_col;
          w_mode  = vga_resolution_mode;
          w_empty = (w_sel_w == '0) || (w_sel_h == '0);
          w_cx    = '0;
          w_cy    = '0;
          w_busy  = 1'b1;
          w_ack   = w_grant;
          if (!((w_sel_w == '0) || (w_sel_h == '0))) begin
            w_x  = w_sel_x0;
            w_y  = w_sel_y0;
            w_we = in_bounds(w_sel_x0, '0, w_sel_y0, '0, vga_resolution_mode);
          end
        end
      end
      S_DRAW: begin
        if (w_last) begin
          w_state = S_DONE;
          w_done  = NUM_REQ'(1) << r_idx;
        end else begin
          if (r_cx == r_w - XW'(1)) begin
            w_cx = '0;
            w_cy = r_cy + YW'(1);
          end else begin
            w_cx = r_cx + XW'(1);
          end
          w_x  = r_x0 + w_cx;
          w_y  = r_y0 + w_cy;
          w_we = in_bounds(r_x0, w_cx, r_y0, w_cy, r_mode);
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
        w_ptr   = (r_idx == IW'(NUM_REQ-1)) ? '0 : r_idx + IW'(1);
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE; r_ptr <= '0;  r_idx   <= '0;
      r_x0    <= '0;     r_y0  <= '0;  r_w     <= '0; r_h <= '0;
      r_col   <= '0;     r_mode <= 1'b0; r_empty <= 1'b0;
      r_cx    <= '0;     r_cy  <= '0;  r_x     <= '0; r_y <= '0;
      r_we    <= 1'b0;   r_busy <= 1'b0; r_ack <= '0; r_done <= '0;
    end else begin
      r_state <= w_state; r_ptr <= w_ptr; r_idx   <= w_idx_n;
      r_x0    <= w_x0;    r_y0  <= w_y0;  r_w     <= w_w; r_h <= w_h;
      r_col   <= w_col;   r_mode <= w_mode; r_empty <= w_empty;
      r_cx    <= w_cx;    r_cy  <= w_cy;  r_x     <= w_x; r_y <= w_y;
      r_we    <= w_we;    r_busy <= w_busy; r_ack <= w_ack; r_done <= w_done;
    end
  end

  assign req_ack  = r_ack;
  assign req_done = r_done;
  assign busy     = r_busy;
  assign x        = r_x;
  assign y        = r_y;
  assign colour   = r_col_out();
  assign writeEn  = r_we;

  // Colour output only changes on a grant, so the latched request colour drives it directly.
  function automatic logic [COLOUR_W-1:0] r_col_out();
    return r_col;
  endfunction
endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Scoreboard bench for vga_draw_scheduler: expected pixel writes are queued when a
// request is set up and popped as the DUT rasters them.
module tb_vga_draw_scheduler;
  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        vga_resolution_mode;
  logic [1:0]  req_valid;
  logic [17:0] req_x0, req_w;
  logic [15:0] req_y0, req_h;
  logic [5:0]  req_colour;
  logic [1:0]  req_ack, req_done;
  logic        busy, writeEn;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [2:0]  colour;

  typedef struct packed {
    logic       we;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  vga_draw_scheduler #(.NUM_REQ(2), .XW(9), .YW(8)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .vga_resolution_mode(vga_resolution_mode),
    .req_valid(req_valid), .req_x0(req_x0), .req_y0(req_y0), .req_w(req_w),
    .req_h(req_h), .req_colour(req_colour), .req_ack(req_ack), .req_done(req_done),
    .busy(busy), .x(x), .y(y), .colour(colour), .writeEn(writeEn)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_req(input int r, input int x0, input int y0, input int w,
                         input int h, input int c);
    req_x0[r*9 +: 9]     = 9'(x0);
    req_y0[r*8 +: 8]     = 8'(y0);
    req_w[r*9 +: 9]      = 9'(w);
    req_h[r*8 +: 8]      = 8'(h);
    req_colour[r*3 +: 3] = 3'(c);
  endtask

  task automatic push_fill(input int x0, input int y0, input int w, input int h,
                           input int c, input int m);
    int   xmax, ymax, px, py;
    pix_t e;
    xmax = (m != 0) ? 320 : 160;
    ymax = (m != 0) ? 240 : 120;
    for (int cy = 0; cy < h; cy++) begin
      for (int cx = 0; cx < w; cx++) begin
        px   = x0 + cx;
        py   = y0 + cy;
        e.we = (px < xmax) && (py < ymax);
        e.x  = 9'(px);
        e.y  = 8'(py);
        e.c  = 3'(c);
        exp_q.push_back(e);
      end
    end
  endtask

  // Waits for the grant of requester r, checks every DRAW cycle against the queue, then the done pulse.
  task automatic serve(input int r, input int w, input int h, input bit drop,
                       output int wc, output int nwe);
    bit         got;
    int         cyc;
    logic [1:0] onehot;
    pix_t       e, act;
    onehot = 2'(1 << r);
    got = 1'b0;
    wc  = 0;
    nwe = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      wc++;
      if (req_ack != 2'b00) got = 1'b1;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL ack_timeout req%0d: no ack within 40 cycles, required ack=%b", r, onehot);
      return;
    end
    n_tests++;
    if (req_ack !== onehot || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_vec req%0d: got ack=%b busy=%b, required ack=%b busy=1", r, req_ack, busy, onehot);
    end
    if (drop) req_valid[r] = 1'b0;
    cyc = (w * h == 0) ? 1 : w * h;
    for (int k = 0; k < cyc; k++) begin
      if (k > 0) step();
      if (writeEn === 1'b1) nwe++;
      n_tests++;
      if (w * h == 0) begin
        if (writeEn !== 1'b0) begin
          n_fail++;
          $display("FAIL empty_we req%0d: writeEn=%b, required 0", r, writeEn);
        end
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow req%0d cycle %0d: no expected pixel queued", r, k);
      end else begin
        e   = exp_q.pop_front();
        act = '{we: writeEn, x: x, y: y, c: colour};
        if (act !== e) begin
          n_fail++;
          $display("FAIL pixel req%0d cycle %0d: got we=%b x=%0d y=%0d c=%0d, required we=%b x=%0d y=%0d c=%0d",
                   r, k, act.we, act.x, act.y, act.c, e.we, e.x, e.y, e.c);
        end
      end
    end
    step();
    n_tests++;
    if (req_done !== onehot || writeEn !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL done req%0d: got done=%b we=%b busy=%b, required done=%b we=0 busy=1",
               r, req_done, writeEn, busy, onehot);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vga_resolution_mode = 1'b0;
    req_valid = '0; req_x0 = '0; req_y0 = '0; req_w = '0; req_h = '0; req_colour = '0;
    repeat (2) step();
    n_tests++;
    if ({req_ack, req_done, busy, x, y, colour, writeEn} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack=%b done=%b busy=%b x=%0d y=%0d c=%0d we=%b, required all 0",
               req_ack, req_done, busy, x, y, colour, writeEn);
    end
    reset = 1'b0;
    step();
    n_tests++;
    if (busy !== 1'b0 || req_ack !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b ack=%b, required 0/00", busy, req_ack);
    end
  endtask

  task automatic test_single();
    int wc, nwe;
    set_req(0, 10, 20, 3, 2, 3'b100);
    push_fill(10, 20, 3, 2, 3'b100, 0);
    req_valid[0] = 1'b1;
    serve(0, 3, 2, 1'b1, wc, nwe);
    n_tests++;
    if (nwe != 6) begin
      n_fail++;
      $display("FAIL single_count: got %0d writes, required 6", nwe);
    end
  endtask

  task automatic test_round_robin();
    int wc, nwe;
    reset = 1'b1;
    step();
    set_req(0, 1, 1, 2, 1, 1);
    set_req(1, 50, 60, 1, 2, 2);
    push_fill(1, 1, 2, 1, 1, 0);
    push_fill(50, 60, 1, 2, 2, 0);
    req_valid = 2'b11;
    reset = 1'b0;
    serve(0, 2, 1, 1'b1, wc, nwe);
    serve(1, 1, 2, 1'b1, wc, nwe);
    n_tests++;
    if (wc != 2) begin
      n_fail++;
      $display("FAIL back_to_back_gap: got %0d cycles from done to ack, required 2", wc);
    end
    push_fill(1, 1, 2, 1, 1, 0);
    push_fill(50, 60, 1, 2, 2, 0);
    req_valid = 2'b11;
    serve(0, 2, 1, 1'b1, wc, nwe);
    serve(1, 1, 2, 1'b1, wc, nwe);
  endtask

  task automatic test_clip_lo();
    int wc, nwe;
    vga_resolution_mode = 1'b0;
    set_req(0, 158, 118, 4, 4, 5);
    push_fill(158, 118, 4, 4, 5, 0);
    req_valid[0] = 1'b1;
    serve(0, 4, 4, 1'b1, wc, nwe);
    n_tests++;
    if (nwe != 4) begin
      n_fail++;
      $display("FAIL clip_lo_count: got %0d writes, required 4", nwe);
    end
  endtask

  task automatic test_empty();
    int wc, nwe;
    set_req(1, 30, 30, 0, 5, 7);
    req_valid[1] = 1'b1;
    serve(1, 0, 5, 1'b1, wc, nwe);
    n_tests++;
    if (nwe != 0) begin
      n_fail++;
      $display("FAIL empty_count: got %0d writes, required 0", nwe);
    end
  endtask

  task automatic test_reset_mid_draw();
    int   wc, nwe;
    bit   got;
    pix_t e, act;
    set_req(0, 5, 5, 4, 4, 1);
    push_fill(5, 5, 4, 4, 1, 0);
    req_valid[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (req_ack[0] === 1'b1) got = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      if (k > 0) step();
      e   = exp_q.pop_front();
      act = '{we: writeEn, x: x, y: y, c: colour};
      n_tests++;
      if (!got || act !== e) begin
        n_fail++;
        $display("FAIL pre_abort_pixel %0d: got we=%b x=%0d y=%0d, required we=%b x=%0d y=%0d",
                 k, act.we, act.x, act.y, e.we, e.x, e.y);
      end
    end
    step();
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({req_ack, req_done, busy, x, y, colour, writeEn} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got done=%b busy=%b x=%0d y=%0d we=%b, required all 0",
               req_done, busy, x, y, writeEn);
    end
    exp_q.delete();
    step();
    n_tests++;
    if (req_done !== 2'b00 || writeEn !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: got done=%b we=%b, required 00/0", req_done, writeEn);
    end
    reset = 1'b0;
    push_fill(5, 5, 4, 4, 1, 0);
    serve(0, 4, 4, 1'b1, wc, nwe);
  endtask

  task automatic test_clip_hi();
    int wc, nwe;
    vga_resolution_mode = 1'b1;
    set_req(1, 300, 10, 30, 1, 6);
    push_fill(300, 10, 30, 1, 6, 1);
    req_valid[1] = 1'b1;
    fork
      begin
        @(posedge req_ack[1]);
        #3 vga_resolution_mode = 1'b0;
      end
    join_none
    serve(1, 30, 1, 1'b1, wc, nwe);
    n_tests++;
    if (nwe != 20) begin
      n_fail++;
      $display("FAIL clip_hi_count: got %0d writes, required 20", nwe);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_clip_lo();
    test_empty();
    test_reset_mid_draw();
    test_clip_hi();
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
